// File: rtl/lane_packer_pkg.sv
// lane_packer_pkg: shared types and helpers for the lane packer.
//   lp_state_t   : packer state (LP_FILL accepts lanes, LP_HOLD waits for
//                  the output register to free up)
//   lp_idx_width : width of the lane index counter for a given lane count
package lane_packer_pkg;

   typedef enum logic {
      LP_FILL = 1'b0,
      LP_HOLD = 1'b1
   } lp_state_t;

   function automatic int lp_idx_width(input int lanes);
      return $clog2(lanes);
   endfunction

endpackage

// File: rtl/lane_packer_if.sv
// lane_packer_if: input lane stream and packed output word of lane_packer.
//   in_valid/in_ready/in_data/in_last : one lane sample per handshake
//   out_valid/out_ready               : packed word handshake
//   out_data/out_mask                 : packed word and per-lane fill mask
//   out_parity                        : per-lane even parity, present only
//                                       when LANE_PACKER_PARITY_EN is defined
// Modports: master = producer/consumer side, slave = the packer.
interface lane_packer_if
   import lane_packer_pkg::*;
#(
   parameter int LANES = 4,
   parameter int WIDTH = 8
);
   logic                         in_valid;
   logic                         in_ready;
   logic [WIDTH-1:0]             in_data;
   logic                         in_last;
   logic                         out_valid;
   logic                         out_ready;
   logic [LANES-1:0][WIDTH-1:0]  out_data;
   logic [LANES-1:0]             out_mask;
`ifdef LANE_PACKER_PARITY_EN
   logic [LANES-1:0]             out_parity;
`endif

   modport master (
      output in_valid, in_data, in_last, out_ready,
`ifdef LANE_PACKER_PARITY_EN
      input  out_parity,
`endif
      input  in_ready, out_valid, out_data, out_mask
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
`ifdef LANE_PACKER_PARITY_EN
      output out_parity,
`endif
      output in_ready, out_valid, out_data, out_mask
   );

endinterface

// File: rtl/lane_parity_calc.sv
// lane_parity_calc: combinational per-lane even parity (XOR-reduce).
//   i_data   : packed lanes [LANES-1:0][WIDTH-1:0]
//   o_parity : bit i = ^i_data[i]
// Only instantiated when LANE_PACKER_PARITY_EN is defined.
module lane_parity_calc
   import lane_packer_pkg::*;
#(
   parameter int LANES = 4,
   parameter int WIDTH = 8
) (
   input  logic [LANES-1:0][WIDTH-1:0] i_data,
   output logic [LANES-1:0]            o_parity
);

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_par
         assign o_parity[gi] = ^i_data[gi];
      end
   endgenerate

endmodule

// File: rtl/lane_packer.sv
// lane_packer: gathers serial lane samples into a packed multi-lane word.
//   clock  : single rising-edge clock
//   reset  : synchronous, active-high
//   lp_bus : lane_packer_if.slave (input lane stream, packed word output)
// Optional feature: LANE_PACKER_PARITY_EN adds a registered per-lane parity
// output computed by lane_parity_calc.
// One word accumulates while the previous one is presented; a completed word
// that cannot be loaded parks in the accumulator (LP_HOLD) with input stalled.
module lane_packer
   import lane_packer_pkg::*;
#(
   parameter int LANES = 4,
   parameter int WIDTH = 8
) (
   input  logic         clock,
   input  logic         reset,
   lane_packer_if.slave lp_bus
);

   localparam int            IW       = lp_idx_width(LANES);
   localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);

   lp_state_t                   r_state, w_state_next;
   logic [IW-1:0]               r_idx, w_idx_next;
   logic [LANES-1:0][WIDTH-1:0] r_acc_data, w_acc_data_upd;
   logic [LANES-1:0]            r_acc_mask, w_acc_mask_upd;
   logic                        r_out_valid;
   logic [LANES-1:0][WIDTH-1:0] r_out_data;
   logic [LANES-1:0]            r_out_mask;
   logic                        w_in_ready, w_in_xfer, w_out_free;
   logic                        w_complete, w_load;

   // Registered-state decode only: no path from out_ready into in_ready.
   assign w_in_ready = (r_state == LP_FILL) && !reset;
   assign w_in_xfer  = lp_bus.in_valid && w_in_ready;
   assign w_out_free = !r_out_valid || lp_bus.out_ready;

   // Accumulator view including this cycle's sample, so a completing lane
   // goes straight into the output register on the same edge.
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         logic w_hit;
         assign w_hit              = w_in_xfer && (r_idx == IW'(gi));
         assign w_acc_data_upd[gi] = w_hit ? lp_bus.in_data : r_acc_data[gi];
         assign w_acc_mask_upd[gi] = w_hit | r_acc_mask[gi];
      end
   endgenerate

   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      w_complete   = 1'b0;
      w_load       = 1'b0;
      case (r_state)
         LP_FILL: begin
            if (w_in_xfer) begin
               w_complete = (r_idx == LAST_IDX) || lp_bus.in_last;
               if (!w_complete) begin
                  w_idx_next = r_idx + 1'b1;
               end else if (w_out_free) begin
                  w_load = 1'b1;
               end else begin
                  w_state_next = LP_HOLD;
               end
            end
         end
         LP_HOLD: begin
            if (w_out_free) begin
               w_load       = 1'b1;
               w_state_next = LP_FILL;
            end
         end
         default: w_state_next = LP_FILL;
      endcase
      if (w_load) begin
         w_idx_next = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= LP_FILL;
         r_idx       <= '0;
         r_acc_data  <= '0;
         r_acc_mask  <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_mask  <= '0;
      end else begin
         r_state <= w_state_next;
         r_idx   <= w_idx_next;
         if (w_load) begin
            r_acc_data  <= '0;
            r_acc_mask  <= '0;
            r_out_valid <= 1'b1;
            r_out_data  <= w_acc_data_upd;
            r_out_mask  <= w_acc_mask_upd;
         end else begin
            r_acc_data <= w_acc_data_upd;
            r_acc_mask <= w_acc_mask_upd;
            if (lp_bus.out_ready) begin
               r_out_valid <= 1'b0;
            end
         end
      end
   end

   assign lp_bus.in_ready  = w_in_ready;
   assign lp_bus.out_valid = r_out_valid;
   assign lp_bus.out_data  = r_out_data;
   assign lp_bus.out_mask  = r_out_mask;

`ifdef LANE_PACKER_PARITY_EN
   logic [LANES-1:0] w_parity;
   logic [LANES-1:0] r_out_parity;

   // Unfilled lanes are zero in the accumulator, so their parity is zero.
   lane_parity_calc #(
      .LANES (LANES),
      .WIDTH (WIDTH)
   ) u_parity (
      .i_data   (w_acc_data_upd),
      .o_parity (w_parity)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_out_parity <= '0;
      end else if (w_load) begin
         r_out_parity <= w_parity;
      end
   end

   assign lp_bus.out_parity = r_out_parity;
`endif

endmodule

// File: tb/tb_lane_packer.sv
// tb_lane_packer: directed bench for lane_packer (LANES=4, WIDTH=8).
// A word-level model (queue of completed words, list of pending lanes) is
// checked against the DUT on every falling edge; directed scenarios add
// hand-computed literal expectations.
`timescale 1ns/1ps
module tb_lane_packer;
   localparam int LANES = 4;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lane_packer_if #(.LANES(LANES), .WIDTH(WIDTH)) lp_if();

   lane_packer #(.LANES(LANES), .WIDTH(WIDTH)) dut (
      .clock  (clk),
      .reset  (rst),
      .lp_bus (lp_if)
   );

   int n_pass  = 0;
   int n_total = 0;
   int n_dut_out = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

`ifdef LANE_PACKER_PARITY_EN
   function automatic logic [3:0] par_of(input logic [31:0] w);
      logic [3:0] p;
      for (int i = 0; i < 4; i++) p[i] = ^w[i*8 +: 8];
      return p;
   endfunction
`endif

   // ---------------- word-level model and per-cycle compare ----------------
   logic [31:0] q_data[$];
   logic [3:0]  q_mask[$];
   logic [7:0]  part[$];
   bit          armed = 0;
   bit          fresh = 0;

   always @(negedge clk) begin : mon
      logic        exp_rdy;
      logic [31:0] w;
      logic [3:0]  m;
      exp_rdy = !rst && (q_data.size() < 2);
      if (lp_if.out_valid === 1'b1 && lp_if.out_ready === 1'b1 && !rst) n_dut_out++;
      if (armed) begin
         chk("in_ready", lp_if.in_ready, exp_rdy);
         chk("out_valid", lp_if.out_valid, q_data.size() > 0);
         if (q_data.size() > 0) begin
            chk("out_data", lp_if.out_data, q_data[0]);
            chk("out_mask", lp_if.out_mask, q_mask[0]);
`ifdef LANE_PACKER_PARITY_EN
            chk("out_parity", lp_if.out_parity, par_of(q_data[0]));
`endif
         end else if (fresh) begin
            chk("idle_data_zero", lp_if.out_data, 0);
            chk("idle_mask_zero", lp_if.out_mask, 0);
`ifdef LANE_PACKER_PARITY_EN
            chk("idle_parity_zero", lp_if.out_parity, 0);
`endif
         end
      end
      if (rst) begin
         armed = 1;
         fresh = 1;
         q_data.delete();
         q_mask.delete();
         part.delete();
      end else if (armed) begin
         if (q_data.size() > 0 && lp_if.out_ready) begin
            void'(q_data.pop_front());
            void'(q_mask.pop_front());
         end
         if (lp_if.in_valid && exp_rdy) begin
            part.push_back(lp_if.in_data);
            if (lp_if.in_last || part.size() == LANES) begin
               w = '0;
               m = '0;
               for (int i = 0; i < part.size(); i++) begin
                  w[i*8 +: 8] = part[i];
                  m[i] = 1'b1;
               end
               q_data.push_back(w);
               q_mask.push_back(m);
               part.delete();
               fresh = 0;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 of the accepting edge.
   task automatic send(input logic [7:0] d, input logic l);
      int budget;
      budget = 50;
      lp_if.in_valid = 1'b1;
      lp_if.in_data  = d;
      lp_if.in_last  = l;
      @(negedge clk);
      while (lp_if.in_ready !== 1'b1 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) chk("send_timeout", lp_if.in_ready, 1);
      @(posedge clk);
      #1;
      lp_if.in_valid = 1'b0;
      lp_if.in_data  = '0;
      lp_if.in_last  = 1'b0;
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ----------------
   initial begin : stim
      time t0;
      int  n0;
      lp_if.in_valid  = 1'b0;
      lp_if.in_data   = '0;
      lp_if.in_last   = 1'b0;
      lp_if.out_ready = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready_low", lp_if.in_ready, 0);
      chk("reset_out_valid", lp_if.out_valid, 0);
      rst = 1'b0;
      #1;
      chk("post_reset_in_ready", lp_if.in_ready, 1);
      idle(1);

      // Full word
      send(8'hA5, 0); send(8'hF1, 0); send(8'h96, 0); send(8'hAC, 0);
      chk("full_valid", lp_if.out_valid, 1);
      chk("full_data", lp_if.out_data, 32'hAC96F1A5);
      chk("full_mask", lp_if.out_mask, 4'b1111);

      // Partial word
      send(8'h11, 0); send(8'h22, 1);
      chk("partial_data", lp_if.out_data, 32'h00002211);
      chk("partial_mask", lp_if.out_mask, 4'b0011);
      idle(3);

      // Backpressure
      lp_if.out_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 0);
      chk("bp_word0_valid", lp_if.out_valid, 1);
      chk("bp_word0_data", lp_if.out_data, 32'h13121110);
      chk("bp_hold_in_ready", lp_if.in_ready, 0);
      lp_if.in_valid = 1'b1;
      lp_if.in_data  = 8'h99;
      idle(3);
      chk("bp_ninth_blocked", lp_if.in_ready, 0);
      chk("bp_word0_stable", lp_if.out_data, 32'h13121110);
      lp_if.out_ready = 1'b1;
      idle(1);
      lp_if.out_ready = 1'b0;
      chk("bp_word1_valid", lp_if.out_valid, 1);
      chk("bp_word1_data", lp_if.out_data, 32'h17161514);
      chk("bp_ready_back", lp_if.in_ready, 1);
      idle(1);
      lp_if.in_valid = 1'b0;
      send(8'h9A, 1);
      lp_if.out_ready = 1'b1;
      idle(5);

      // Streaming
      t0 = $time;
      for (int i = 1; i <= 16; i++) begin
         send(8'(i), 0);
         chk("stream_valid", lp_if.out_valid, (i % 4) == 0);
         if ((i % 4) == 0)
            chk("stream_data", lp_if.out_data, {8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)});
      end
      chk("stream_cycles", ($time - t0) / 10, 16);
      idle(3);

      // Reset mid-word
      send(8'hE1, 0); send(8'hE2, 0);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      chk("rst_mid_valid", lp_if.out_valid, 0);
      chk("rst_mid_data", lp_if.out_data, 0);
      chk("rst_mid_mask", lp_if.out_mask, 0);
      n0 = n_dut_out;
      send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
      chk("rst_word_data", lp_if.out_data, 32'h04030201);
      chk("rst_word_mask", lp_if.out_mask, 4'b1111);
      idle(3);
      chk("rst_word_count", n_dut_out - n0, 1);

      // Parity vector
      send(8'h01, 0); send(8'h03, 0); send(8'h07, 0); send(8'hFF, 0);
      chk("par_word_data", lp_if.out_data, 32'hFF070301);
`ifdef LANE_PACKER_PARITY_EN
      chk("par_value", lp_if.out_parity, 4'b0101);
`endif
      idle(4);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
